// File: rtl/freelist_alloc_pkg.sv
// Shared types and sizing for the physical-register free list.
// Width defaults are set here to keep tag widths consistent across the design.
package freelist_alloc_pkg;

    localparam int FL_N = 3;

    localparam int FL_PHYS_REGS = 64;

    // Physical registers owned by the architectural map out of reset.
    localparam int FL_ARCH_REGS = 32;

    localparam int FL_TAG_W = $clog2(FL_PHYS_REGS);

    typedef logic [FL_TAG_W-1:0] PHYS_TAG;

    // One retire-side free request.
    typedef struct packed {
        logic    valid;
        PHYS_TAG tag;
    } FREELIST_FREE_PACKET;

    // Advance a tag by one, wrapping at the pool size.
    function automatic PHYS_TAG tag_wrap_inc(input PHYS_TAG t, input int modulus);
        if (int'(t) >= modulus - 1) begin
            return '0;
        end
        return t + PHYS_TAG'(1);
    endfunction

endpackage

// File: rtl/freelist_alloc_nth_select.sv
// Combinational "i-th set bit" finder for the free list.
// The search starts at start_i and wraps around the pool. sel_o[i] is the
// one-hot position of the (i+1)-th set bit of free_map_i in that order. It
// is all zeros when fewer than i+1 bits are set.
module freelist_nth_select #(
    parameter int N         = 3,
    parameter int PHYS_REGS = 64,
    parameter int TAG_W     = $clog2(PHYS_REGS)
) (
    input  logic [PHYS_REGS-1:0]        free_map_i,
    input  logic [TAG_W-1:0]            start_i,
    output logic [N-1:0][PHYS_REGS-1:0] sel_o
);

    logic [2*PHYS_REGS-1:0]      map_dbl;
    logic [2*PHYS_REGS-1:0]      map_shift;
    logic [PHYS_REGS-1:0]        map_rot;
    logic [N-1:0][PHYS_REGS-1:0] sel_rot;

    // Rotate the map so that search position 0 sits at bit 0.
    assign map_dbl   = {free_map_i, free_map_i};
    assign map_shift = map_dbl >> start_i;
    assign map_rot   = map_shift[PHYS_REGS-1:0];

    // Walk the rotated map once, handing the k-th set bit to slot k.
    always_comb begin
        int seen;
        sel_rot = '0;
        seen    = 0;
        for (int k = 0; k < PHYS_REGS; k++) begin
            if (map_rot[k]) begin
                for (int i = 0; i < N; i++) begin
                    if (seen == i) begin
                        sel_rot[i][k] = 1'b1;
                    end
                end
                seen = seen + 1;
            end
        end
    end

    // Rotate each selection back into absolute tag positions.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unrot
            logic [2*PHYS_REGS-1:0] back_shift;
            assign back_shift = {sel_rot[gi], sel_rot[gi]} << start_i;
            assign sel_o[gi]  = back_shift[2*PHYS_REGS-1:PHYS_REGS];
        end
    endgenerate

endmodule

// File: rtl/freelist_alloc.sv
// Physical-register free list and N-way allocator for the R10K rename path.
// Free tags are offered to the dispatch slots as one-hot grants. Only the
// grants that dispatch takes are committed. Retired tags are reclaimed, and
// recovery rebuilds the pool from the retirement map's used-mask.
// Optional build macro FREELIST_ROTATE_EN: the search starts from a
// rotating head pointer instead of tag 0.
module freelist_alloc
    import freelist_alloc_pkg::*;
#(
    parameter int N         = FL_N,
    parameter int PHYS_REGS = FL_PHYS_REGS,
    parameter int ARCH_REGS = FL_ARCH_REGS,
    localparam int CNT_W    = $clog2(PHYS_REGS + 1),
    localparam int TAG_W    = $clog2(PHYS_REGS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N-1:0]                alloc_req,
    output logic [N-1:0][PHYS_REGS-1:0] granted_regs,
    output logic [CNT_W-1:0]            free_slots,
    input  logic [N-1:0]                free_valid,
    input  PHYS_TAG [N-1:0]             free_tag,
    input  logic                        recover_valid,
    input  logic [PHYS_REGS-1:0]        recover_used_mask,
    output logic                        err_flag
);

    logic [PHYS_REGS-1:0] free_map_q, free_map_d;
    logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
    logic                 err_q, err_d;

    logic [PHYS_REGS-1:0] reset_map;
    logic [TAG_W-1:0]     search_start;
    logic [N-1:0]         grant_vld;

    logic [PHYS_REGS-1:0] alloc_mask;
    logic [CNT_W-1:0]     n_alloc;
    logic                 alloc_err;

    FREELIST_FREE_PACKET [N-1:0] free_pkt;
    logic [PHYS_REGS-1:0] free_mask;
    logic [CNT_W-1:0]     n_free;
    logic                 free_err;

    logic [CNT_W-1:0]     used_pop;

    // Architectural tags start busy, the rest of the pool starts free.
    generate
        for (genvar gi = 0; gi < PHYS_REGS; gi++) begin : g_rst_map
            assign reset_map[gi] = (gi >= ARCH_REGS) ? 1'b1 : 1'b0;
        end
    endgenerate

`ifdef FREELIST_ROTATE_EN
    logic [TAG_W-1:0]     head_q, head_d;
    logic [N-1:0][TAG_W-1:0] grant_tag;
    logic [TAG_W-1:0]     last_tag;
    logic                 any_alloc;

    assign search_start = head_q;

    // Encode each one-hot grant so the head can follow the last accepted tag.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_enc
            always_comb begin
                grant_tag[gi] = '0;
                for (int k = 0; k < PHYS_REGS; k++) begin
                    if (granted_regs[gi][k]) begin
                        grant_tag[gi] = grant_tag[gi] | TAG_W'(k);
                    end
                end
            end
        end
    endgenerate

    // Higher slots sit later in search order, so the last accepted slot wins.
    always_comb begin
        last_tag  = '0;
        any_alloc = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (alloc_req[i] && grant_vld[i]) begin
                last_tag  = grant_tag[i];
                any_alloc = 1'b1;
            end
        end
    end

    // Head moves past the newest allocation and snaps back on recovery.
    always_comb begin
        head_d = head_q;
        if (recover_valid) begin
            head_d = TAG_W'(ARCH_REGS);
        end else if (any_alloc) begin
            head_d = tag_wrap_inc(last_tag, PHYS_REGS);
        end
    end

    // Head pointer register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q <= TAG_W'(ARCH_REGS);
        end else begin
            head_q <= head_d;
        end
    end
`else
    assign search_start = '0;
`endif

    freelist_nth_select #(
        .N         (N),
        .PHYS_REGS (PHYS_REGS),
        .TAG_W     (TAG_W)
    ) u_nth_select (
        .free_map_i (free_map_q),
        .start_i    (search_start),
        .sel_o      (granted_regs)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_vld
            assign grant_vld[gi] = |granted_regs[gi];
        end
    endgenerate

    // Collect the grants dispatch actually consumes and flag requests for missing ones.
    always_comb begin
        alloc_mask = '0;
        n_alloc    = '0;
        alloc_err  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (alloc_req[i]) begin
                if (grant_vld[i]) begin
                    alloc_mask = alloc_mask | granted_regs[i];
                    n_alloc    = n_alloc + CNT_W'(1);
                end else begin
                    alloc_err = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pkt
            assign free_pkt[gi].valid = free_valid[gi];
            assign free_pkt[gi].tag   = free_tag[gi];
        end
    endgenerate

    // Accept retire frees of busy tags and reject frees of tags already free.
    // This includes the second free of a tag freed twice in the same cycle.
    always_comb begin
        free_mask = '0;
        n_free    = '0;
        free_err  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (free_pkt[i].valid) begin
                if (free_map_q[free_pkt[i].tag] || free_mask[free_pkt[i].tag]) begin
                    free_err = 1'b1;
                end else begin
                    free_mask[free_pkt[i].tag] = 1'b1;
                    n_free = n_free + CNT_W'(1);
                end
            end
        end
    end

    assign used_pop = CNT_W'($countones(recover_used_mask));

    // Next pool state. Recovery replaces the pool and discards this cycle's traffic.
    always_comb begin
        free_map_d = (free_map_q & ~alloc_mask) | free_mask;
        free_cnt_d = free_cnt_q - n_alloc + n_free;
        err_d      = err_q | alloc_err | free_err;
        if (recover_valid) begin
            free_map_d = ~recover_used_mask;
            free_cnt_d = CNT_W'(PHYS_REGS) - used_pop;
            err_d      = err_q;
        end
    end

    // Pool, count and sticky error registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            free_map_q <= reset_map;
            free_cnt_q <= CNT_W'(PHYS_REGS - ARCH_REGS);
            err_q      <= 1'b0;
        end else begin
            free_map_q <= free_map_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign free_slots = free_cnt_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_freelist_alloc.sv
// Scoreboard bench for freelist_alloc: directed scenarios followed by random traffic.
module tb_freelist_alloc;
    import freelist_alloc_pkg::*;

    localparam int NS = FL_N;
    localparam int P  = FL_PHYS_REGS;
    localparam int A  = FL_ARCH_REGS;
    localparam int CW = $clog2(P + 1);

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic [NS-1:0]          alloc_req = '0;
    logic [NS-1:0][P-1:0]   granted_regs;
    logic [CW-1:0]          free_slots;
    logic [NS-1:0]          free_valid = '0;
    PHYS_TAG [NS-1:0]       free_tag = '0;
    logic                   recover_valid = 1'b0;
    logic [P-1:0]           recover_used_mask = '0;
    logic                   err_flag;

    freelist_alloc dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_req         (alloc_req),
        .granted_regs      (granted_regs),
        .free_slots        (free_slots),
        .free_valid        (free_valid),
        .free_tag          (free_tag),
        .recover_valid     (recover_valid),
        .recover_used_mask (recover_used_mask),
        .err_flag          (err_flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NS-1:0][P-1:0] grants;
        int                   slots;
        bit                   err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cycle = 0;

    // Reference model: a plain array of free flags plus the sticky error.
    bit   m_free[P];
    bit   m_err;
    int   m_head;
    bit   model_valid = 0;
    int   offer[NS];
    int   n_offer;

    function automatic void compute_offers();
        int start;
        n_offer = 0;
        for (int i = 0; i < NS; i++) offer[i] = -1;
`ifdef FREELIST_ROTATE_EN
        start = m_head;
`else
        start = 0;
`endif
        for (int k = 0; k < P; k++) begin
            int t;
            t = (start + k) % P;
            if (m_free[t] && n_offer < NS) begin
                offer[n_offer] = t;
                n_offer++;
            end
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        compute_offers();
        e.grants = '0;
        for (int i = 0; i < n_offer; i++) e.grants[i][offer[i]] = 1'b1;
        e.slots = 0;
        for (int t = 0; t < P; t++) e.slots += m_free[t];
        e.err = m_err;
        exp_q.push_back(e);
    endfunction

    function automatic void model_step(input bit rst, input logic [NS-1:0] al,
                                       input logic [NS-1:0] fv, input PHYS_TAG [NS-1:0] ft,
                                       input bit rv, input logic [P-1:0] mask);
        bit start_free[P];
        bit freed_now[P];
        int last;
        bit any;
        if (!rst) begin
            for (int t = 0; t < P; t++) m_free[t] = (t >= A);
            m_err  = 0;
            m_head = A;
            return;
        end
        if (rv) begin
            for (int t = 0; t < P; t++) m_free[t] = !mask[t];
            m_head = A;
            return;
        end
        compute_offers();
        start_free = m_free;
        for (int t = 0; t < P; t++) freed_now[t] = 0;
        any  = 0;
        last = 0;
        for (int i = 0; i < NS; i++) begin
            if (al[i]) begin
                if (i < n_offer) begin
                    m_free[offer[i]] = 0;
                    last = offer[i];
                    any  = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (fv[i]) begin
                int t;
                t = int'(ft[i]);
                if (start_free[t] || freed_now[t]) begin
                    m_err = 1;
                end else begin
                    freed_now[t] = 1;
                    m_free[t] = 1;
                end
            end
        end
        if (any) m_head = (last + 1) % P;
    endfunction

    // One clock: record what the DUT must show now, then drive the next inputs.
    task automatic do_cycle(input bit rst, input logic [NS-1:0] al,
                            input logic [NS-1:0] fv, input PHYS_TAG [NS-1:0] ft,
                            input bit rv, input logic [P-1:0] mask);
        @(posedge clock);
        #1;
        if (model_valid) push_expected();
        reset             = rst;
        alloc_req         = al;
        free_valid        = fv;
        free_tag          = ft;
        recover_valid     = rv;
        recover_used_mask = mask;
        model_step(rst, al, fv, ft, rv, mask);
        model_valid = 1;
    endtask

    task automatic idle();
        do_cycle(1'b1, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        do_cycle(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Monitor: compare every recorded expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cycle++;
                for (int i = 0; i < NS; i++) begin
                    n_tests++;
                    if (granted_regs[i] !== e.grants[i]) begin
                        n_fail++;
                        $display("FAIL grant%0d cyc %0d: got %h want %h", i, n_cycle,
                                 granted_regs[i], e.grants[i]);
                    end
                end
                n_tests++;
                if (free_slots !== CW'(e.slots)) begin
                    n_fail++;
                    $display("FAIL free_slots cyc %0d: got %0d want %0d", n_cycle, free_slots, e.slots);
                end
                n_tests++;
                if (err_flag !== e.err) begin
                    n_fail++;
                    $display("FAIL err_flag cyc %0d: got %0b want %0b", n_cycle, err_flag, e.err);
                end
                $display("[TB] cyc %0d slots=%0d err=%0b g0=%h", n_cycle, free_slots, err_flag,
                         granted_regs[0]);
            end
        end
    end

    initial begin
        PHYS_TAG [NS-1:0] ft;
        logic [NS-1:0]    fv;
        logic [P-1:0]     mask;
        bit               used[P];

        // Reset and idle: pool 32..63 free, no error.
        do_reset();
        do_reset();
        idle();
        // Full allocation.
        do_cycle(1'b1, 3'b111, '0, '0, 1'b0, '0);
        idle();

        // Sparse request from reset state.
        do_reset();
        do_cycle(1'b1, 3'b010, '0, '0, 1'b0, '0);
        idle();

        // Exhaustion down to a single free tag, then over-request.
        do_reset();
        for (int r = 0; r < 10; r++) do_cycle(1'b1, 3'b111, '0, '0, 1'b0, '0);
        do_cycle(1'b1, 3'b001, '0, '0, 1'b0, '0);
        idle();
        do_cycle(1'b1, 3'b011, '0, '0, 1'b0, '0);
        idle();

        // Free tag 5, then free it again.
        ft = '0;
        ft[0] = PHYS_TAG'(5);
        do_cycle(1'b1, '0, 3'b001, ft, 1'b0, '0);
        idle();
        do_cycle(1'b1, '0, 3'b001, ft, 1'b0, '0);
        idle();

        // Double free within one cycle on a clean pool.
        do_reset();
        ft = '0;
        ft[0] = PHYS_TAG'(7);
        ft[1] = PHYS_TAG'(7);
        do_cycle(1'b1, '0, 3'b011, ft, 1'b0, '0);
        idle();

        // Recovery overriding simultaneous alloc and free.
        do_reset();
        mask = '0;
        for (int t = 0; t < 32; t++) mask[t] = 1'b1;
        mask[40] = 1'b1;
        ft = '0;
        ft[0] = PHYS_TAG'(3);
        do_cycle(1'b1, 3'b111, 3'b001, ft, 1'b1, mask);
        idle();
        idle();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [NS-1:0] al;
            al = NS'($urandom);
            fv = '0;
            ft = '0;
            for (int t = 0; t < P; t++) used[t] = 0;
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    for (int tries = 0; tries < 16; tries++) begin
                        int t;
                        t = $urandom_range(0, P - 1);
                        if (!m_free[t] && !used[t]) begin
                            used[t] = 1;
                            fv[i] = 1'b1;
                            ft[i] = PHYS_TAG'(t);
                            break;
                        end
                    end
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                mask = {$urandom, $urandom};
                do_cycle(1'b1, al, fv, ft, 1'b1, mask);
            end else if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                do_cycle(1'b1, al, fv, ft, 1'b0, '0);
            end
        end
        idle();
        idle();
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/freelist_alloc.md
Name: freelist_alloc

Overview:
- Physical-register free list and N-way allocator for the R10K rename path.
- Tracks every physical register as free or busy and offers up to `N free tags per cycle to the dispatch slots as one-hot grants.
- Commits only the grants dispatch actually takes, and reclaims tags freed at retire.
- Rebuilds the whole pool in one cycle on branch-mispredict recovery, using the retirement map's used-mask.

Parameters:
- N, `N: dispatch/retire width.
- PHYS_REGS, `PHYS_REG_SZ_R10K: physical register count, default 64.
- ARCH_REGS, 32: number of physical registers owned by the architectural map at reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset; state clears on a clock edge while reset==0.
- alloc_req  in  [N]  slot i consumes its offered grant at this edge.
- granted_regs  out  [N][PHYS_REGS]  one-hot tag offered to slot i; all zeros if unavailable.
- free_slots  out  [$clog2(PHYS_REGS+1)]  registered count of free registers.
- free_valid  in  [N]  retire frees a tag this edge.
- free_tag  in  [N] x PHYS_TAG  tag to free (retired Told).
- recover_valid  in  1  mispredict recovery.
- recover_used_mask  in  [PHYS_REGS]  bit set = tag held by the retirement map.
- err_flag  out  1  sticky protocol error.

Behaviour:
- State:
  - free_map[PHYS_REGS]: 1 = free.
  - free_cnt register, driving free_slots.
  - err register.
- Reset (reset==0 at edge):
  - free_map bits 0..ARCH_REGS-1 = 0, remaining bits = 1.
  - free_cnt = PHYS_REGS-ARCH_REGS.
  - err = 0.
- Grants:
  - Combinational from free_map only. They do not depend on alloc_req (no loop through dispatch).
  - Slot i is offered the (i+1)-th free tag in search order, so slot offers are distinct.
  - If fewer than i+1 tags are free, granted_regs[i] = 0.
  - Non-contiguous requests are legal. Example: only slot 1 requests; it takes the 2nd free tag and the 1st stays free.
- Alloc commit (edge): for each i with alloc_req[i] and a nonzero grant, clear that tag's free_map bit.
  - alloc_req[i] with a zero grant is ignored and sets err.
- Free commit (edge): for each i with free_valid[i], set free_map[free_tag[i]].
  - If that tag is already free, or is freed twice in the same cycle, set err and leave the bit at 1.
- No same-cycle bypass. A freed tag is first offered in the next cycle. Alloc and free targets are disjoint by construction.
- Count update: free_cnt_next = free_cnt - (number of accepted allocs) + (number of accepted frees). Always equals popcount(free_map) after the edge.
- Recovery (recover_valid=1) overrides alloc and free in the same cycle:
  - free_map = ~recover_used_mask.
  - free_cnt = PHYS_REGS - popcount(recover_used_mask).
  - err is unchanged.
- free_slots reflects the start-of-cycle state, 1-cycle latency after any change.
- Reset mid-operation: reset wins over recovery, alloc and free.

Optional Feature:
- FREELIST_ROTATE_EN defined:
  - Search order starts at a registered head pointer and wraps modulo PHYS_REGS.
  - Head reset value = ARCH_REGS.
  - On an edge with any accepted alloc, head = (highest-order accepted tag in search order) + 1, mod PHYS_REGS.
  - On recovery, head = ARCH_REGS.
- Undefined: search order is lowest index first, and there is no head register.

Decomposition:
- PHYS_TAG, `N and `PHYS_REG_SZ_R10K already live in sys_defs.svh.
- Add FREELIST_FREE_PACKET {valid, tag} to the shared package.
- Sub-module freelist_nth_select: combinational; takes free_map and start index, returns N one-hot "i-th set bit" vectors. Instantiated once.

Test Plan:
- Reset:
  - Release reset -> free_slots=32.
  - granted_regs one-hot at 32, 33, 34 (N=3).
  - err=0.
- Full alloc:
  - alloc_req=3'b111 -> next cycle free_slots=29; grants 35, 36, 37.
- Sparse request:
  - alloc_req=3'b010 from reset state -> tag 33 busy; next grants 32, 34, 35; free_slots=31.
- Exhaustion:
  - Allocate until free_slots=1 -> grant0 valid, grants 1 and 2 zero.
  - alloc_req=3'b011 -> slot0 accepted, err=1, free_slots=0.
- Free and double free:
  - free tag 5 -> next cycle free_slots+1 and tag 5 offered (lowest-first).
  - Free tag 5 again -> err=1, count unchanged.
- Recovery:
  - recover_valid with mask = bits 0..31 set plus 40, while simultaneously alloc_req=3'b111 and a free -> alloc and free ignored; free_slots=31; grants 32, 33, 34.
